// File: rtl/xor_fold_compactor.sv
// Streaming XOR-fold compactor: folds each channel's DW-bit word down to DW/FOLD bits and
// optionally XOR-accumulates folded words over a latched frame length into one signature.
module xor_fold_compactor #(
    parameter int DW   = 16,
    parameter int FOLD = 2,
    parameter int NCH  = 2,
    parameter int CW   = 8,
    localparam int OW  = DW / FOLD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [CW-1:0]       acc_len,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*DW-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH*OW-1:0]   out_data
);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic              mode_q, mode_d;
    logic [NCH*OW-1:0] acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [NCH*OW-1:0] out_data_q, out_data_d;

    logic [NCH*OW-1:0] fold;
    logic [NCH*OW-1:0] combined;
    logic              accept;
    logic              first_beat;
    logic              last_beat;
    logic              eff_mode;
    logic [CW-1:0]     eff_len;
    logic [CW:0]       beat_num;

    always_comb begin
        fold = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < FOLD; k++) begin
                fold[c*OW +: OW] = fold[c*OW +: OW] ^ in_data[c*DW + k*OW +: OW];
            end
        end
    end

    // Single output register with no skid buffer: a stalled result blocks all input.
    assign in_ready   = !flush && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);

    // At a frame start the live mode/length apply; afterwards only the latched copies do.
    assign eff_mode = first_beat ? mode : mode_q;
    assign eff_len  = first_beat ? ((acc_len == '0) ? CW'(1) : acc_len) : len_q;
    assign beat_num = {1'b0, cnt_q} + 1'b1;
    assign last_beat = !eff_mode || (beat_num == {1'b0, eff_len});
    assign combined  = first_beat ? fold : (acc_q ^ fold);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (first_beat) begin
                mode_d = mode;
                len_d  = eff_len;
            end
            if (last_beat) begin
                cnt_d       = '0;
                out_data_d  = combined;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = combined;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_xor_fold_compactor.sv
// Self-checking bench for xor_fold_compactor: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a frame-level reference model.
module tb_xor_fold_compactor;

    localparam int DW   = 16;
    localparam int FOLD = 2;
    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int OW   = DW / FOLD;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mode = 1'b0;
    logic [CW-1:0]       acc_len = '0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [NCH*DW-1:0]   in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [NCH*OW-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    xor_fold_compactor #(.DW(DW), .FOLD(FOLD), .NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .acc_len   (acc_len),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model: frame contents kept as a list of folded words, reduced at frame end.
    logic             m_ov = 1'b0;
    logic [15:0]      m_od = '0;
    logic [15:0]      m_frame[$];
    int               m_len = 0;
    logic             m_mode = 1'b0;

    function automatic logic [15:0] ref_fold(input logic [31:0] w);
        longint unsigned r = 0;
        for (int c = 0; c < NCH; c++) begin
            longint unsigned ch = (longint'(w) >> (c*DW)) & 64'hFFFF;
            longint unsigned v = 0;
            for (int k = 0; k < FOLD; k++) v = v ^ ((ch >> (k*OW)) & 64'hFF);
            r = r | (v << (c*OW));
        end
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set(input logic m, input logic [7:0] len, input logic fl,
                       input logic v, input logic r, input logic [31:0] d);
        mode = m; acc_len = len; flush = fl; in_valid = v; out_ready = r; in_data = d;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        logic exp_ready;
        logic ended;
        logic [15:0] x;
        #1;
        exp_ready = !flush && (!m_ov || out_ready);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        @(posedge clk);
        ended = 1'b0;
        if (flush) begin
            m_frame.delete();
        end else if (in_valid && exp_ready) begin
            if (m_frame.size() == 0) begin
                m_mode = mode;
                m_len  = (acc_len == 0) ? 1 : int'(acc_len);
            end
            m_frame.push_back(ref_fold(in_data));
            if (!m_mode || m_frame.size() == m_len) begin
                x = '0;
                foreach (m_frame[i]) x = x ^ m_frame[i];
                m_od = x;
                ended = 1'b1;
                m_frame.delete();
            end
        end
        if (ended) m_ov = 1'b1;
        else if (m_ov && out_ready) m_ov = 1'b0;
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        check("out_data", {16'b0, out_data}, {16'b0, m_od});
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        m_ov = 1'b0; m_od = '0; m_frame.delete(); m_len = 0; m_mode = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic        mode;
        logic [7:0]  acc_len;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [31:0] in_data;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 32'h1234_A5F0, 1'b1, 16'h2655};
        vecs[1] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_0001, 1'b1, 16'h0001};
        vecs[2] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 16'h0001};
        vecs[3] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0304, 1'b0, 16'h0001};
        vecs[4] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 32'h0000_0508, 1'b1, 16'h0009};
        vecs[5] = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 16'h0009};
        vecs[6] = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b1, 32'h00AB_0000, 1'b1, 16'hAB00};
        vecs[7] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 16'hAB00};

        // Reset state
        #2;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", {16'b0, out_data}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            set(vecs[i].mode, vecs[i].acc_len, vecs[i].flush, vecs[i].in_valid,
                vecs[i].out_ready, vecs[i].in_data);
            cycle();
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_data", i), {16'b0, out_data}, {16'b0, vecs[i].exp_data});
        end

        // Back-pressure: result held, input blocked for 5 cycles
        set(0, 0, 0, 1, 0, 32'h0011_0022);
        cycle();
        check("bp_first", {16'b0, out_data}, 32'h1122);
        for (int i = 0; i < 5; i++) begin
            set(0, 0, 0, 1, 0, $urandom);
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            cycle();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_data", {16'b0, out_data}, 32'h1122);
        end
        set(0, 0, 0, 0, 1, 32'h0);
        cycle();
        check("bp_release", {31'b0, out_valid}, 32'd0);
        set(0, 0, 0, 1, 0, 32'h0011_0022);
        cycle();
        set(0, 0, 0, 1, 1, 32'h0F0F_00FF);
        cycle();
        check("bp_reload_valid", {31'b0, out_valid}, 32'd1);
        check("bp_reload_data", {16'b0, out_data}, 32'h00FF);

        // Mode/length change mid-frame is ignored until the next frame
        set(1, 4, 0, 1, 1, 32'h0000_0100); cycle();
        set(1, 4, 0, 1, 1, 32'h0000_0200); cycle();
        set(0, 2, 0, 1, 1, 32'h0000_0400); cycle();
        check("chg_no_early_end", {31'b0, out_valid}, 32'd0);
        set(0, 2, 0, 1, 1, 32'h0000_0800); cycle();
        check("chg_end_valid", {31'b0, out_valid}, 32'd1);
        check("chg_end_data", {16'b0, out_data}, 32'h000F);
        set(0, 2, 0, 1, 1, 32'h0000_1000); cycle();
        check("chg_next_mode0", {16'b0, out_data}, 32'h0010);

        // Flush discards partial frame and drops a concurrent beat
        set(1, 3, 0, 1, 1, 32'h0000_0102); cycle();
        set(1, 3, 0, 1, 1, 32'h0000_0304); cycle();
        set(1, 3, 1, 1, 1, 32'h0000_0508); cycle();
        check("flush_no_out", {31'b0, out_valid}, 32'd0);
        set(1, 3, 0, 1, 1, 32'h0000_0102); cycle();
        set(1, 3, 0, 1, 1, 32'h0000_0304); cycle();
        check("flush_mid", {31'b0, out_valid}, 32'd0);
        set(1, 3, 0, 1, 1, 32'h0000_0508); cycle();
        check("flush_clean_data", {16'b0, out_data}, 32'h0009);

        // Reset with a pending result, then with a partial frame
        set(1, 3, 0, 0, 0, 32'h0);
        cycle();
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        mid_reset();
        set(1, 3, 0, 1, 1, 32'h0000_0102); cycle();
        set(1, 3, 0, 1, 1, 32'h0000_0304); cycle();
        mid_reset();
        set(1, 3, 0, 1, 1, 32'h0000_0102); cycle();
        set(1, 3, 0, 1, 1, 32'h0000_0304); cycle();
        set(1, 3, 0, 1, 1, 32'h0000_0508); cycle();
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_data", {16'b0, out_data}, 32'h0009);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            set(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
